inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
- Writable instruction memory with a byte-stream program loader.
- While loading: accepts bytes over a valid/ready handshake, packs them big-endian into 32-bit words, writes words to a 32-entry instruction RAM.
- While running: serves combinational word fetches to the CPU on Addr/Inst.
- Holds the CPU while loading, so the exception/interrupt handler area (words 0x15–0x1e) can be reloaded without resynthesis.

Parameters:
- DEPTH, 32, number of 32-bit instruction words (address index width = log2(DEPTH) = 5).
- RESET_WORD, 32'h00000000, value all RAM words take on reset (0 = sll R0,R0,0 nop).

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- Clrn  input  1  asynchronous active-low reset.
- Load_Start  input  1  one-cycle pulse; begins a load when in IDLE.
- Load_Words  input  6  number of words to load, sampled at Load_Start; legal 1..32.
- Byte_In  input  8  next program byte, MSB-first within each word.
- Byte_Valid  input  1  Byte_In valid this cycle.
- Byte_Ready  output  1  loader accepts a byte this cycle.
- Addr  input  32  CPU fetch byte address; word index = Addr[6:2].
- Inst  output  32  instruction word at Addr[6:2]; combinational read.
- Cpu_Hold  output  1  high while loading; the CPU must not advance its PC.
- Load_Done  output  1  one-cycle pulse when the final word is written.
- Load_Err  output  1  sticky error flag; cleared by the next accepted Load_Start.

Behaviour:
- Reset (Clrn=0, async):
  - state=IDLE, all RAM words=RESET_WORD.
  - Byte_Ready=0, Cpu_Hold=0, Load_Done=0, Load_Err=0; word/byte counters=0.
- States: IDLE, RECV, WRITE, CHECK (CHECK exists only with the optional feature).
- IDLE:
  - Byte_Ready=0.
  - On Load_Start: if Load_Words is 0 or >32, set Load_Err=1 and stay in IDLE.
  - Otherwise: clear Load_Err, latch count, word_idx=0, byte_idx=0, go to RECV. Cpu_Hold=1 from the next cycle.
- RECV:
  - Byte_Ready=1. A byte transfers when Byte_Valid && Byte_Ready.
  - Shift register: word = {word[23:0], Byte_In}.
  - byte_idx increments; on the 4th byte go to WRITE.
- WRITE (one cycle):
  - Byte_Ready=0; RAM[word_idx] <= assembled word.
  - If word_idx == count-1: go to CHECK (feature on) or IDLE (feature off), and pulse Load_Done in this cycle.
  - Else: word_idx++, byte_idx=0, back to RECV.
- Throughput: at most 4 bytes per 5 cycles. Valid-without-ready holds the byte (no drop). Byte_Valid during IDLE/WRITE is ignored.
- Cpu_Hold=1 in RECV, WRITE and CHECK; it falls the cycle after returning to IDLE.
- Load_Start outside IDLE is ignored.
- Read path: Inst = RAM[Addr[6:2]]. Addr[1:0] and Addr[31:7] are ignored, so addresses wrap modulo 128 bytes.
  - Reading a word in the WRITE cycle returns the old value; the new value is visible the next cycle.
- Words beyond count are untouched (partial load keeps prior contents).
- Reset mid-load: async abort to reset state. The RAM is reinitialised and the partial program is discarded.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- With it: after the last WRITE, go to CHECK with Byte_Ready=1 and accept one extra byte.
  - That byte must equal the 8-bit two's-complement sum of all program bytes, such that sum+checksum == 8'h00.
  - On mismatch: Load_Err=1 and every loaded word is overwritten with RESET_WORD; the rewrite adds at most count extra cycles with Cpu_Hold=1.
  - Load_Done pulses on leaving CHECK instead of on the last WRITE.
- Without it: no CHECK state and no checksum byte; Load_Done pulses at the last WRITE; Load_Err is driven only by an illegal Load_Words.

Test Plan:
- Reset then Addr=0x00,0x04,0x7C -> Inst=RESET_WORD; Cpu_Hold=0, Byte_Ready=0, Load_Done=0.
- Load_Words=2, bytes 40,0A,E0,00,35,4A,02,00 back-to-back valid -> RAM[0]=0x400AE000, RAM[1]=0x354A0200; Load_Done one pulse; Cpu_Hold high throughout, low after; Inst@Addr=0x04 = 0x354A0200; RAM[2] unchanged.
- Same load with Byte_Valid toggled 1-0-1 and idle gaps of 3 cycles -> identical RAM contents; no bytes lost or duplicated.
- Load_Words=0 and Load_Words=33 -> Load_Err=1, state stays IDLE, Cpu_Hold=0; then a valid Load_Start clears Load_Err.
- Load 32 words, then Load_Start again during RECV -> second start ignored; Clrn pulsed low after word 10 -> all words=RESET_WORD, outputs at reset values.
- With LOADER_CHECKSUM_EN: Load_Words=1, bytes 3C,01,80,08, checksum 0x3B -> Load_Err=0, RAM[0]=0x3C018008. Checksum 0x3C -> Load_Err=1, RAM[0]=RESET_WORD.

Source files
------------

// File: rtl/inst_loader.sv
// inst_loader: 32-word writable instruction memory with a byte-stream loader.
// Bytes arrive over valid/ready, are packed MSB-first into 32-bit words and
// written to the RAM; the CPU is held while a load is in progress and reads
// words combinationally on Addr/Inst otherwise.
// Optional build macro LOADER_CHECKSUM_EN adds a trailing checksum byte; on a
// mismatch the loaded words are wiped back to RESET_WORD.
//
// Handshake: a byte transfers on a rising edge where Byte_Valid && Byte_Ready;
// Byte_Valid without Byte_Ready holds the byte (the sender keeps it stable),
// and Byte_Ready never depends combinationally on Byte_Valid.
module inst_loader #(
   parameter int          DEPTH      = 32,
   parameter logic [31:0] RESET_WORD = 32'h00000000,
   localparam int         AW         = $clog2(DEPTH)
) (
   input  logic          Clk,
   input  logic          Clrn,
   input  logic          Load_Start,
   input  logic [AW:0]   Load_Words,
   input  logic [7:0]    Byte_In,
   input  logic          Byte_Valid,
   output logic          Byte_Ready,
   input  logic [31:0]   Addr,
   output logic [31:0]   Inst,
   output logic          Cpu_Hold,
   output logic          Load_Done,
   output logic          Load_Err,
   output logic [1:0]    dbg_state
);

`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, WRITE = 2'd2, CHECK = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, WRITE = 2'd2} state_t;
`endif

   state_t         state;
   logic [AW:0]    count;
   logic [AW-1:0]  word_idx;
   logic [1:0]     byte_idx;
   logic [31:0]    word_sr;
   logic [31:0]    mem [DEPTH];
   logic           byte_xfer;
   logic           last_word;
   logic           bad_words;
   logic           ram_we;
   logic [31:0]    ram_wdata;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]     sum;
   logic           wiping;
`endif

   assign byte_xfer = Byte_Valid && Byte_Ready;
   assign last_word = ({1'b0, word_idx} == (count - 1'b1));
   assign bad_words = (Load_Words == '0) || (Load_Words > (AW+1)'(DEPTH));
   assign dbg_state = state;

   // Read path: word index from Addr, byte offset and upper bits ignored
   assign Inst = mem[Addr[AW+1:2]];

   // RAM write port: assembled word in WRITE, RESET_WORD while wiping
   always_comb begin
      ram_we    = (state == WRITE);
      ram_wdata = word_sr;
`ifdef LOADER_CHECKSUM_EN
      if (state == CHECK && wiping) begin
         ram_we    = 1'b1;
         ram_wdata = RESET_WORD;
      end
`endif
   end

   // Instruction RAM; reset reinitialises every word
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_WORD;
      end else if (ram_we) begin
         mem[word_idx] <= ram_wdata;
      end
   end

   // Loader FSM with registered handshake and status outputs
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         state      <= IDLE;
         count      <= '0;
         word_idx   <= '0;
         byte_idx   <= '0;
         word_sr    <= '0;
         Byte_Ready <= 1'b0;
         Cpu_Hold   <= 1'b0;
         Load_Done  <= 1'b0;
         Load_Err   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum        <= '0;
         wiping     <= 1'b0;
`endif
      end else begin
         Load_Done <= 1'b0;
         case (state)
            IDLE: begin
               Byte_Ready <= 1'b0;
               if (Load_Start) begin
                  if (bad_words) begin
                     Load_Err <= 1'b1;
                  end else begin
                     Load_Err   <= 1'b0;
                     count      <= Load_Words;
                     word_idx   <= '0;
                     byte_idx   <= '0;
                     state      <= RECV;
                     Byte_Ready <= 1'b1;
                     Cpu_Hold   <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                     sum        <= '0;
                     wiping     <= 1'b0;
`endif
                  end
               end
            end
            RECV: begin
               if (byte_xfer) begin
                  word_sr  <= {word_sr[23:0], Byte_In};
                  byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                  sum      <= sum + Byte_In;
`endif
                  if (byte_idx == 2'd3) begin
                     state      <= WRITE;
                     Byte_Ready <= 1'b0;
`ifndef LOADER_CHECKSUM_EN
                     Load_Done  <= last_word;
`endif
                  end
               end
            end
            WRITE: begin
               if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                  state      <= CHECK;
                  Byte_Ready <= 1'b1;
`else
                  state      <= IDLE;
                  Cpu_Hold   <= 1'b0;
`endif
               end else begin
                  word_idx   <= word_idx + 1'b1;
                  byte_idx   <= '0;
                  state      <= RECV;
                  Byte_Ready <= 1'b1;
               end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
               if (wiping) begin
                  if (last_word) begin
                     wiping    <= 1'b0;
                     state     <= IDLE;
                     Cpu_Hold  <= 1'b0;
                     Load_Done <= 1'b1;
                  end else begin
                     word_idx <= word_idx + 1'b1;
                  end
               end else if (byte_xfer) begin
                  Byte_Ready <= 1'b0;
                  if (8'(sum + Byte_In) == 8'h00) begin
                     state     <= IDLE;
                     Cpu_Hold  <= 1'b0;
                     Load_Done <= 1'b1;
                  end else begin
                     Load_Err <= 1'b1;
                     wiping   <= 1'b1;
                     word_idx <= '0;
                  end
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: directed bench for inst_loader with hand-computed words.
module tb_inst_loader;

   logic        Clk;
   logic        Clrn;
   logic        Load_Start;
   logic [5:0]  Load_Words;
   logic [7:0]  Byte_In;
   logic        Byte_Valid;
   logic        Byte_Ready;
   logic [31:0] Addr;
   logic [31:0] Inst;
   logic        Cpu_Hold;
   logic        Load_Done;
   logic        Load_Err;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_pass   = 0;
   int done_cnt = 0;
   int hold_gap = 0;
   bit in_load  = 0;
   logic [7:0]  prog_q[$];
   logic [31:0] exp_q[$];

   inst_loader dut (
      .Clk(Clk), .Clrn(Clrn), .Load_Start(Load_Start), .Load_Words(Load_Words),
      .Byte_In(Byte_In), .Byte_Valid(Byte_Valid), .Byte_Ready(Byte_Ready),
      .Addr(Addr), .Inst(Inst), .Cpu_Hold(Cpu_Hold), .Load_Done(Load_Done),
      .Load_Err(Load_Err), .dbg_state(dbg_state)
   );

   // clock / reset
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // monitor: Load_Done pulses and Cpu_Hold during a load
   always @(negedge Clk) begin
      if (Load_Done) begin
         done_cnt++;
         in_load = 0;
      end else if (in_load && !Cpu_Hold) begin
         hold_gap++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      Addr = a;
      #1;
      check(tag, Inst, exp);
   endtask

   // drive one byte and hold it until accepted (bounded)
   task automatic send_byte(input logic [7:0] b);
      bit ok;
      ok = 0;
      Byte_In    = b;
      Byte_Valid = 1'b1;
      for (int c = 0; c < 100; c++) begin
         ok = Byte_Ready;
         cyc();
         if (ok) break;
      end
      if (!ok) check("byte_accept_timeout", 32'(ok), 32'd1);
   endtask

   task automatic do_load(input int n, input bit gapped, input bit ck_forced,
                          input logic [7:0] ck_val, input bit watch,
                          input logic [31:0] old_w, input logic [31:0] new_w);
      int d0;
      bit seen;
      logic [7:0] sum;
      logic [7:0] ck;
      d0  = done_cnt;
      sum = 8'h00;
      Load_Words = 6'(n);
      Load_Start = 1'b1;
      cyc();
      Load_Start = 1'b0;
      in_load    = 1;
      for (int i = 0; i < prog_q.size(); i++) begin
         send_byte(prog_q[i]);
         sum = sum + prog_q[i];
         if (watch && i == 3) begin
            Byte_Valid = 1'b0;
            check("read_in_write_old", Inst, old_w);
            cyc();
            check("read_after_write_new", Inst, new_w);
         end
         if (gapped) begin
            Byte_Valid = 1'b0;
            repeat ((i % 2) ? 3 : 1) cyc();
         end
      end
`ifdef LOADER_CHECKSUM_EN
      ck = ck_forced ? ck_val : (8'h00 - sum);
      send_byte(ck);
`else
      ck = ck_val;
      if (ck_forced && ck == 8'h00) ck = sum;
`endif
      Byte_Valid = 1'b0;
      seen = 0;
      for (int c = 0; c < 60; c++) begin
         if (done_cnt != d0) begin
            seen = 1;
            break;
         end
         cyc();
      end
      check("load_done_seen", 32'(seen), 32'd1);
      repeat (3) cyc();
      check("load_done_once", 32'(done_cnt - d0), 32'd1);
      check("cpu_hold_during_load", 32'(hold_gap), 32'd0);
      check("cpu_hold_after_load", 32'(Cpu_Hold), 32'd0);
      in_load = 0;
   endtask

   initial begin
      Clrn = 1'b0; Load_Start = 1'b0; Load_Words = '0;
      Byte_In = '0; Byte_Valid = 1'b0; Addr = '0;
      #12;
      // reset state
      read_chk("rst_inst_00", 32'h00, 32'h0);
      read_chk("rst_inst_04", 32'h04, 32'h0);
      read_chk("rst_inst_7c", 32'h7C, 32'h0);
      check("rst_cpu_hold", 32'(Cpu_Hold), 32'd0);
      check("rst_byte_ready", 32'(Byte_Ready), 32'd0);
      check("rst_load_done", 32'(Load_Done), 32'd0);
      check("rst_load_err", 32'(Load_Err), 32'd0);
      @(negedge Clk);
      Clrn = 1'b1;
      cyc();

      // back-to-back two-word load
      prog_q = '{8'h40, 8'h0A, 8'hE0, 8'h00, 8'h35, 8'h4A, 8'h02, 8'h00};
      do_load(2, 0, 0, 8'h00, 0, '0, '0);
      exp_q = '{32'h400AE000, 32'h354A0200};
      read_chk("b2b_ram0", 32'h00, exp_q.pop_front());
      read_chk("b2b_ram1", 32'h04, exp_q.pop_front());
      read_chk("b2b_ram2_untouched", 32'h08, 32'h0);
      read_chk("addr_wrap_84", 32'h84, 32'h354A0200);
      read_chk("addr_offset_07", 32'hFFFF_FF87, 32'h354A0200);

      // different contents, then the same program with gaps and valid toggling
      prog_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      do_load(2, 0, 0, 8'h00, 0, '0, '0);
      read_chk("pre_ram0", 32'h00, 32'h11223344);
      prog_q = '{8'h40, 8'h0A, 8'hE0, 8'h00, 8'h35, 8'h4A, 8'h02, 8'h00};
      Addr = 32'h00;
      do_load(2, 1, 0, 8'h00, 1, 32'h11223344, 32'h400AE000);
      read_chk("gap_ram0", 32'h00, 32'h400AE000);
      read_chk("gap_ram1", 32'h04, 32'h354A0200);

      // illegal word counts
      Load_Words = 6'd0; Load_Start = 1'b1; cyc(); Load_Start = 1'b0;
      check("zero_err", 32'(Load_Err), 32'd1);
      check("zero_state_idle", 32'(dbg_state), 32'd0);
      check("zero_hold", 32'(Cpu_Hold), 32'd0);
      Load_Words = 6'd33; Load_Start = 1'b1; cyc(); Load_Start = 1'b0;
      check("w33_err", 32'(Load_Err), 32'd1);
      check("w33_state_idle", 32'(dbg_state), 32'd0);
      check("w33_ready", 32'(Byte_Ready), 32'd0);
      // valid start clears the error; one-word partial load keeps word 1
      prog_q = '{8'h12, 8'h34, 8'h56, 8'h78};
      do_load(1, 0, 0, 8'h00, 0, '0, '0);
      check("err_cleared", 32'(Load_Err), 32'd0);
      read_chk("partial_ram0", 32'h00, 32'h12345678);
      read_chk("partial_ram1_kept", 32'h04, 32'h354A0200);

      // 32-word load, ignored restart, reset after ten words
      Load_Words = 6'd32; Load_Start = 1'b1; cyc(); Load_Start = 1'b0;
      check("full_state_recv", 32'(dbg_state), 32'd1);
      exp_q = {};
      for (int w = 0; w < 10; w++) begin
         logic [31:0] word;
         word = '0;
         for (int k = 0; k < 4; k++) begin
            logic [7:0] b;
            b = 8'h80 + 8'(4 * w + k);
            word = {word[23:0], b};
            send_byte(b);
         end
         exp_q.push_back(word);
         if (w == 3) begin
            Byte_Valid = 1'b0;
            cyc();
            Load_Words = 6'd2; Load_Start = 1'b1; cyc(); Load_Start = 1'b0;
            check("restart_ignored_state", 32'(dbg_state), 32'd1);
            check("restart_ignored_hold", 32'(Cpu_Hold), 32'd1);
         end
      end
      Byte_Valid = 1'b0;
      cyc();
      read_chk("full_ram0", 32'h00, exp_q[0]);
      read_chk("full_ram3", 32'h0C, exp_q[3]);
      read_chk("full_ram9", 32'h24, exp_q[9]);
      read_chk("full_ram10_old", 32'h28, 32'h0);
      check("full_hold_mid", 32'(Cpu_Hold), 32'd1);
      #2 Clrn = 1'b0;
      #1;
      read_chk("abort_ram9", 32'h24, 32'h0);
      read_chk("abort_ram1", 32'h04, 32'h0);
      check("abort_hold", 32'(Cpu_Hold), 32'd0);
      check("abort_ready", 32'(Byte_Ready), 32'd0);
      check("abort_done", 32'(Load_Done), 32'd0);
      check("abort_state", 32'(dbg_state), 32'd0);
      @(negedge Clk);
      Clrn = 1'b1;
      cyc();

`ifdef LOADER_CHECKSUM_EN
      // checksum good then bad
      prog_q = '{8'h3C, 8'h01, 8'h80, 8'h08};
      do_load(1, 0, 1, 8'h3B, 0, '0, '0);
      check("ck_good_err", 32'(Load_Err), 32'd0);
      read_chk("ck_good_ram0", 32'h00, 32'h3C018008);
      do_load(1, 0, 1, 8'h3C, 0, '0, '0);
      check("ck_bad_err", 32'(Load_Err), 32'd1);
      read_chk("ck_bad_ram0", 32'h00, 32'h0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
